comms_command_decoder: RTL and testbench

- Sits directly upstream of core_interface.
- Takes a byte stream from the serial front end and assembles 8-byte command packets: opcode, 24-bit address, 32-bit value.
- Drives the shared instruction/address/value bus seen by all core_interface instances, then serialises READ results back to the host as bytes.
- Owns the packet framing, command issue timing, and response return path.

---
 rtl/comms_command_decoder_pkg.sv | 32 +++
 rtl/comms_byte_serializer.sv | 49 ++++
 rtl/comms_command_decoder.sv | 173 +++++++++++++++++
 tb/tb_comms_command_decoder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comms_command_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : comms_command_decoder_pkg
// Brief  : Shared opcodes, decoder state encoding and packet constants.
// Rev    : 1.0  initial release
// ============================================================================
package comms_command_decoder_pkg;

    typedef enum logic [7:0] {
        NOP   = 8'h00,
        WRITE = 8'h01,
        READ  = 8'h02
    } instructions_e;

    typedef logic [2:0] dec_state_t;

    localparam dec_state_t c_st_idle     = 3'd0;
    localparam dec_state_t c_st_receive  = 3'd1;
    localparam dec_state_t c_st_issue    = 3'd2;
    localparam dec_state_t c_st_wait     = 3'd3;
    localparam dec_state_t c_st_transmit = 3'd4;

    localparam int c_packet_bytes   = 8;
    localparam int c_response_bytes = 4;

    // Opcodes that reach the core_interface bus.
    function automatic logic is_bus_op(input logic [7:0] op);
        return (op == WRITE) || (op == READ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/comms_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module : comms_byte_serializer
// Brief  : Loads a 32-bit word and returns it MSB-first as 4 handshaked bytes.
// Rev    : 1.0  initial release
// ============================================================================
module comms_byte_serializer
    import comms_command_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_load_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_last_xfer
);

    logic [31:0] r_shift;
    logic [1:0]  r_count;
    logic        r_valid;
    logic        w_xfer;

    assign w_xfer      = r_valid & i_tx_ready;
    assign o_last_xfer = w_xfer && (r_count == 2'(c_response_bytes - 1));
    assign o_tx_data   = r_shift[31:24];
    assign o_tx_valid  = r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_load_data;
            r_count <= '0;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_shift <= {r_shift[23:0], 8'h00};
            r_count <= r_count + 2'd1;
            if (o_last_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/comms_command_decoder.sv
`default_nettype none
// ============================================================================
// Module : comms_command_decoder
// Brief  : Frames 8-byte host packets, drives the core bus, returns READ data.
// Rev    : 1.0  initial release
// ============================================================================
module comms_command_decoder
    import comms_command_decoder_pkg::*;
#(
    parameter int ISSUE_CYCLES   = 2,
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  instruction,
    output logic [23:0] address,
    output logic [31:0] value,
    input  logic [31:0] output_value,
    output logic        busy,
    output logic        error
);

    localparam int c_issue_n = (ISSUE_CYCLES   > 1) ? ISSUE_CYCLES   : 1;
    localparam int c_wait_n  = (READ_LATENCY   > 1) ? READ_LATENCY   : 1;
    localparam int c_to_n    = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : 1;
    localparam int c_ph_max  = (c_issue_n > c_wait_n) ? c_issue_n : c_wait_n;
    localparam int c_ph_w    = $clog2(c_ph_max + 1);
    localparam int c_to_w    = $clog2(c_to_n + 1);

    localparam logic [c_ph_w-1:0] c_issue_last = c_ph_w'(c_issue_n - 1);
    localparam logic [c_ph_w-1:0] c_wait_last  = c_ph_w'(c_wait_n - 1);
    localparam logic [c_to_w-1:0] c_to_last    = c_to_w'(c_to_n - 1);
    localparam logic [2:0]        c_last_byte  = 3'(c_packet_bytes - 1);

    dec_state_t        r_state;
    logic              r_rx_ready;
    logic [7:0]        r_opcode;
    logic [47:0]       r_shift;
    logic [2:0]        r_byte_cnt;
    logic [c_to_w-1:0] r_timeout;
    logic [c_ph_w-1:0] r_phase;
    logic [7:0]        r_instr;
    logic [23:0]       r_addr;
    logic [31:0]       r_value;
    logic              r_error;

    logic              w_rx_fire;
    logic [55:0]       w_packet;
    logic              w_load;
    logic              w_ser_last;

    assign w_rx_fire = rx_valid & r_rx_ready;
    assign w_packet  = {r_shift, rx_data};
    assign w_load    = (r_state == c_st_wait) && (r_phase == c_wait_last);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_rx_ready <= 1'b0;
            r_opcode   <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_timeout  <= '0;
            r_phase    <= '0;
            r_instr    <= NOP;
            r_addr     <= '0;
            r_value    <= '0;
            r_error    <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_rx_ready <= 1'b1;
                    if (w_rx_fire) begin
                        r_opcode   <= rx_data;
                        r_byte_cnt <= 3'd1;
                        r_timeout  <= '0;
                        r_state    <= c_st_receive;
                    end
                end
                c_st_receive: begin
                    if (w_rx_fire) begin
                        r_shift    <= w_packet[47:0];
                        r_timeout  <= '0;
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        if (r_byte_cnt == c_last_byte) begin
                            r_byte_cnt <= '0;
                            if (is_bus_op(r_opcode)) begin
                                // Bus is driven straight off the completing byte: one-cycle issue latency.
                                r_instr    <= r_opcode;
                                r_addr     <= w_packet[55:32];
                                r_value    <= w_packet[31:0];
                                r_phase    <= '0;
                                r_rx_ready <= 1'b0;
                                r_state    <= c_st_issue;
                            end else begin
                                r_error <= (r_opcode != NOP);
                                r_state <= c_st_idle;
                            end
                        end
                    end else if (r_timeout == c_to_last) begin
                        r_error    <= 1'b1;
                        r_byte_cnt <= '0;
                        r_timeout  <= '0;
                        r_state    <= c_st_idle;
                    end else begin
                        r_timeout <= r_timeout + 1'b1;
                    end
                end
                c_st_issue: begin
                    if (r_phase == c_issue_last) begin
                        r_instr <= NOP;
                        r_phase <= '0;
                        if (r_opcode == READ) begin
                            r_state <= c_st_wait;
                        end else begin
                            r_rx_ready <= 1'b1;
                            r_state    <= c_st_idle;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                c_st_wait: begin
                    if (w_load) begin
                        r_phase <= '0;
                        r_state <= c_st_transmit;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                c_st_transmit: begin
                    if (w_ser_last) begin
                        r_rx_ready <= 1'b1;
                        r_state    <= c_st_idle;
                    end
                end
                default: begin
                    r_rx_ready <= 1'b0;
                    r_instr    <= NOP;
                    r_state    <= c_st_idle;
                end
            endcase
        end
    end

    comms_byte_serializer u_serializer (
        .clk         (clock),
        .rst         (reset),
        .i_load      (w_load),
        .i_load_data (output_value),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_last_xfer (w_ser_last)
    );

    assign rx_ready    = r_rx_ready;
    assign instruction = r_instr;
    assign address     = r_addr;
    assign value       = r_value;
    assign busy        = (r_state != c_st_idle);
    assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_comms_command_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_comms_command_decoder
// Brief  : Directed self-checking bench for comms_command_decoder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_comms_command_decoder;
    import comms_command_decoder_pkg::*;

    localparam int c_timeout = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  instruction;
    logic [23:0] address;
    logic [31:0] value;
    logic [31:0] output_value = 32'hDEADBEEF;
    logic        busy;
    logic        error;

    int          errors = 0;
    int          checks = 0;
    int          err_pulses = 0;
    int          err_viol = 0;
    logic [7:0]  txq[$];
    logic [7:0]  exp_b[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    comms_command_decoder #(
        .ISSUE_CYCLES   (2),
        .READ_LATENCY   (2),
        .TIMEOUT_CYCLES (c_timeout)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .instruction  (instruction),
        .address      (address),
        .value        (value),
        .output_value (output_value),
        .busy         (busy),
        .error        (error)
    );

    always #5 clock = ~clock;

    // Handshakes complete at the following rising edge; sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset && tx_valid && tx_ready) txq.push_back(tx_data);
        if (error) err_pulses++;
        if (error && instruction != NOP) err_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        while (!rx_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("rx_ready_wait", {31'h0, rx_ready}, 32'h1);
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] op, input logic [23:0] a, input logic [31:0] v);
        send_byte(op);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(v[31:24]);
        send_byte(v[23:16]);
        send_byte(v[15:8]);
        send_byte(v[7:0]);
    endtask

    task automatic wait_tx_valid(input string tag, output int n);
        n = 0;
        while (!tx_valid && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(tag, {31'h0, tx_valid}, 32'h1);
    endtask

    task automatic check_bytes(input string tag);
        logic [31:0] got;
        check({tag, "_count"}, txq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            got = (i < txq.size()) ? {24'h0, txq[i]} : 32'hFFFF_FFFF;
            check(tag, got, {24'h0, exp_b[i]});
        end
    endtask

    initial begin
        int n;
        int hs;
        int p0;
        int seen;
        logic [7:0] d;
        logic v;
        logic r;
        logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        #1 reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", tx_data, 32'h0);
        check("rst_instr", instruction, NOP);
        check("rst_addr", address, 32'h0);
        check("rst_value", value, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_rx_ready", {31'h0, rx_ready}, 32'h1);

        // WRITE: bus held two cycles from the cycle after the last byte.
        txq.delete();
        send_packet(WRITE, 24'h000001, 32'h0000_0003);
        check("wr_instr_c1", instruction, WRITE);
        check("wr_addr", address, 32'h1);
        check("wr_value", value, 32'h3);
        check("wr_busy", {31'h0, busy}, 32'h1);
        check("wr_rx_ready", {31'h0, rx_ready}, 32'h0);
        @(posedge clock); #1;
        check("wr_instr_c2", instruction, WRITE);
        @(posedge clock); #1;
        check("wr_instr_nop", instruction, NOP);
        check("wr_addr_hold", address, 32'h1);
        check("wr_value_hold", value, 32'h3);
        check("wr_idle", {31'h0, busy}, 32'h0);
        repeat (5) @(posedge clock);
        #1;
        check("wr_no_tx", txq.size(), 0);

        // READ with continuous ready.
        txq.delete();
        send_packet(READ, 24'h000002, 32'h0);
        check("rd_instr", instruction, READ);
        check("rd_addr", address, 32'h2);
        wait_tx_valid("rd_tx_valid", n);
        check("rd_latency", n, 4);
        hs = 0;
        n = 0;
        while (hs < 4 && n < 100) begin
            @(negedge clock);
            if (tx_valid && tx_ready) hs++;
            n++;
        end
        check("rd_handshakes", hs, 4);
        @(posedge clock); #1;
        check("rd_busy_fall", {31'h0, busy}, 32'h0);
        check("rd_tx_valid_fall", {31'h0, tx_valid}, 32'h0);
        check_bytes("rd_byte");

        // READ with tx_ready pattern 1-0-0-1.
        txq.delete();
        send_packet(READ, 24'h000002, 32'h0);
        wait_tx_valid("st_tx_valid", n);
        hs = 0;
        for (int i = 0; i < 60 && hs < 4; i++) begin
            tx_ready = pat[i % 4];
            @(negedge clock);
            d = tx_data;
            v = tx_valid;
            r = tx_ready;
            if (v && r) hs++;
            @(posedge clock); #1;
            if (v && !r) begin
                check("stall_data", tx_data, d);
                check("stall_valid", {31'h0, tx_valid}, 32'h1);
            end
        end
        tx_ready = 1'b1;
        check("st_busy_fall", {31'h0, busy}, 32'h0);
        repeat (3) @(posedge clock);
        #1;
        check_bytes("st_byte");

        // Unknown opcode.
        p0 = err_pulses;
        send_packet(8'h7F, 24'h123456, 32'h0);
        check("unk_error", {31'h0, error}, 32'h1);
        check("unk_instr", instruction, NOP);
        @(posedge clock); #1;
        check("unk_error_fall", {31'h0, error}, 32'h0);
        check("unk_idle", {31'h0, busy}, 32'h0);
        repeat (3) @(posedge clock);
        #1;
        check("unk_pulses", err_pulses - p0, 1);
        send_packet(WRITE, 24'h000010, 32'hCAFE_F00D);
        check("unk_wr_instr", instruction, WRITE);
        check("unk_wr_addr", address, 32'h10);
        check("unk_wr_value", value, 32'hCAFE_F00D);
        repeat (4) @(posedge clock);
        #1;

        // Timeout after a partial packet.
        p0 = err_pulses;
        send_byte(WRITE);
        send_byte(8'h00);
        send_byte(8'h00);
        n = 0;
        while (!error && n < c_timeout + 10) begin
            @(posedge clock); #1;
            n++;
        end
        check("to_cycles", n, c_timeout);
        check("to_idle", {31'h0, busy}, 32'h0);
        @(posedge clock); #1;
        check("to_pulses", err_pulses - p0, 1);
        send_packet(WRITE, 24'hABCDEF, 32'h0102_0304);
        check("to_wr_instr", instruction, WRITE);
        check("to_wr_addr", address, 32'h00AB_CDEF);
        check("to_wr_value", value, 32'h0102_0304);
        repeat (4) @(posedge clock);
        #1;

        // Reset while the second response byte is pending.
        txq.delete();
        send_packet(READ, 24'h000002, 32'h0);
        wait_tx_valid("rr_tx_valid", n);
        hs = 0;
        n = 0;
        while (hs < 1 && n < 20) begin
            @(negedge clock);
            if (tx_valid && tx_ready) hs++;
            n++;
        end
        @(posedge clock); #1;
        tx_ready = 1'b0;
        check("rr_second_byte", tx_data, 32'hAD);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rr_tx_valid_async", {31'h0, tx_valid}, 32'h0);
        check("rr_busy_async", {31'h0, busy}, 32'h0);
        check("rr_rx_ready_async", {31'h0, rx_ready}, 32'h0);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        tx_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (tx_valid) seen++;
        end
        check("rr_no_tx", seen, 0);
        check("rr_bytes", txq.size(), 1);
        check("rr_idle", {31'h0, busy}, 32'h0);
        check("rr_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("rr_instr", instruction, NOP);

        check("err_with_instr", err_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
